// File: rtl/axi_stream_extract_header.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_extract_header
// Brief    : Splits a leading 0..W-byte header off an AXI-Stream packet onto
//            m00 and re-aligns the payload to the MSB lane on m01.
//            Optional counters: define AXIS_EXTRACT_HEADER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_extract_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [$clog2(DATA_BYTE_WD+1)-1:0]    hdr_len,
   input  logic                                 s_axis_tvalid,
   input  logic [DATA_WD-1:0]                   s_axis_tdata,
   input  logic [DATA_BYTE_WD-1:0]              s_axis_tkeep,
   input  logic                                 s_axis_tlast,
   output logic                                 s_axis_tready,
   output logic                                 m00_axis_tvalid,
   output logic [DATA_WD-1:0]                   m00_axis_tdata,
   output logic [DATA_BYTE_WD-1:0]              m00_axis_tkeep,
   input  logic                                 m00_axis_tready,
   output logic                                 m01_axis_tvalid,
   output logic [DATA_WD-1:0]                   m01_axis_tdata,
   output logic [DATA_BYTE_WD-1:0]              m01_axis_tkeep,
   output logic                                 m01_axis_tlast,
   input  logic                                 m01_axis_tready,
   output logic                                 hdr_err
`ifdef AXIS_EXTRACT_HEADER_STATS_EN
   ,
   output logic [31:0]                          pkt_cnt,
   output logic [15:0]                          err_cnt
`endif
);

   localparam int              W   = DATA_BYTE_WD;
   localparam int              HW  = $clog2(W + 1);
   localparam logic [HW-1:0]   W_L = HW'(W);
   localparam logic [HW:0]     W_X = (HW + 1)'(W);

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   function automatic logic [HW-1:0] popcnt(input logic [W-1:0] k);
      logic [HW-1:0] n;
      n = '0;
      for (int i = 0; i < W; i++) n = n + HW'(k[i]);
      return n;
   endfunction

   function automatic logic [W-1:0] keep_hi(input logic [HW:0] n);
      logic [W-1:0] ones;
      ones = '1;
      return ~(ones >> n);
   endfunction

   function automatic logic [W-1:0] keep_lo(input logic [HW:0] n);
      logic [W-1:0] ones;
      ones = '1;
      return ~(ones << n);
   endfunction

   state_t                state_q, state_d;
   logic [DATA_WD-1:0]    carry_q, carry_d;
   logic [HW-1:0]         ccnt_q, ccnt_d;
   logic                  m00_valid_q, m00_valid_d;
   logic [DATA_WD-1:0]    m00_data_q, m00_data_d;
   logic [W-1:0]          m00_keep_q, m00_keep_d;
   logic                  m01_valid_q, m01_valid_d;
   logic [DATA_WD-1:0]    m01_data_q, m01_data_d;
   logic [W-1:0]          m01_keep_q, m01_keep_d;
   logic                  m01_last_q, m01_last_d;
   logic                  hdr_err_q, hdr_err_d;

   logic                  w_m00_free, w_m01_free, w_ready, w_hs;
   logic [DATA_WD-1:0]    w_sdata;
   logic [HW-1:0]         w_h, w_k;
   logic [HW:0]           w_t;
   logic [2*DATA_WD-1:0]  w_cat;

   always_comb begin : p_ready
      w_m00_free = !m00_valid_q || m00_axis_tready;
      w_m01_free = !m01_valid_q || m01_axis_tready;
      w_ready    = 1'b0;
      case (state_q)
         ST_HDR:     w_ready = w_m00_free && w_m01_free;
         ST_PAYLOAD: w_ready = w_m01_free;
         default:    w_ready = 1'b0;
      endcase
      if (rst) w_ready = 1'b0;
   end

   assign s_axis_tready = w_ready;
   assign w_hs          = s_axis_tvalid && w_ready;

   // Disabled lanes are zeroed so garbage never reaches carry or outputs.
   always_comb begin : p_datapath
      for (int i = 0; i < W; i++)
         w_sdata[8*i +: 8] = s_axis_tdata[8*i +: 8] & {8{s_axis_tkeep[i]}};
      w_h   = (hdr_len > W_L) ? W_L : hdr_len;
      w_k   = popcnt(s_axis_tkeep);
      w_t   = {1'b0, ccnt_q} + {1'b0, w_k};
      w_cat = {carry_q, {DATA_WD{1'b0}}}
            | ({{DATA_WD{1'b0}}, w_sdata} << {W_L - ccnt_q, 3'b000});
   end

   always_comb begin : p_next
      state_d     = state_q;
      carry_d     = carry_q;
      ccnt_d      = ccnt_q;
      m00_valid_d = m00_valid_q && !m00_axis_tready;
      m00_data_d  = m00_data_q;
      m00_keep_d  = m00_keep_q;
      m01_valid_d = m01_valid_q && !m01_axis_tready;
      m01_data_d  = m01_data_q;
      m01_keep_d  = m01_keep_q;
      m01_last_d  = m01_last_q;
      hdr_err_d   = 1'b0;

      case (state_q)
         ST_HDR: begin
            if (w_hs) begin
               if (w_h == '0) begin
                  carry_d = '0;
                  ccnt_d  = '0;
               end else begin
                  carry_d = w_sdata << {w_h, 3'b000};
                  ccnt_d  = W_L - w_h;
               end
               if (s_axis_tlast && w_h != '0 && w_k <= w_h) begin
                  // Short packet: whatever arrived is the (possibly truncated) header.
                  m00_valid_d = 1'b1;
                  m00_data_d  = w_sdata >> {W_L - w_k, 3'b000};
                  m00_keep_d  = keep_lo({1'b0, w_k});
                  hdr_err_d   = (w_k < w_h);
               end else begin
                  if (w_h != '0) begin
                     m00_valid_d = 1'b1;
                     m00_data_d  = w_sdata >> {W_L - w_h, 3'b000};
                     m00_keep_d  = keep_lo({1'b0, w_h});
                  end
                  if (s_axis_tlast) begin
                     m01_valid_d = 1'b1;
                     m01_data_d  = w_sdata << {w_h, 3'b000};
                     m01_keep_d  = keep_hi({1'b0, w_k} - {1'b0, w_h});
                     m01_last_d  = 1'b1;
                  end else begin
                     if (w_h == '0) begin
                        m01_valid_d = 1'b1;
                        m01_data_d  = w_sdata;
                        m01_keep_d  = '1;
                        m01_last_d  = 1'b0;
                     end
                     state_d = ST_PAYLOAD;
                  end
               end
            end
         end
         ST_PAYLOAD: begin
            if (w_hs) begin
               m01_valid_d = 1'b1;
               m01_data_d  = w_cat[2*DATA_WD-1:DATA_WD];
               if (s_axis_tlast && w_t <= W_X) begin
                  m01_keep_d = keep_hi(w_t);
                  m01_last_d = 1'b1;
                  state_d    = ST_HDR;
               end else begin
                  m01_keep_d = '1;
                  m01_last_d = 1'b0;
                  carry_d    = w_cat[DATA_WD-1:0];
                  if (s_axis_tlast) begin
                     ccnt_d  = HW'(w_t - W_X);
                     state_d = ST_FLUSH;
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (w_m01_free) begin
               m01_valid_d = 1'b1;
               m01_data_d  = carry_q;
               m01_keep_d  = keep_hi({1'b0, ccnt_q});
               m01_last_d  = 1'b1;
               state_d     = ST_HDR;
            end
         end
         default: state_d = ST_HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HDR;
         carry_q     <= '0;
         ccnt_q      <= '0;
         m00_valid_q <= 1'b0;
         m00_data_q  <= '0;
         m00_keep_q  <= '0;
         m01_valid_q <= 1'b0;
         m01_data_q  <= '0;
         m01_keep_q  <= '0;
         m01_last_q  <= 1'b0;
         hdr_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         carry_q     <= carry_d;
         ccnt_q      <= ccnt_d;
         m00_valid_q <= m00_valid_d;
         m00_data_q  <= m00_data_d;
         m00_keep_q  <= m00_keep_d;
         m01_valid_q <= m01_valid_d;
         m01_data_q  <= m01_data_d;
         m01_keep_q  <= m01_keep_d;
         m01_last_q  <= m01_last_d;
         hdr_err_q   <= hdr_err_d;
      end
   end

   assign m00_axis_tvalid = m00_valid_q;
   assign m00_axis_tdata  = m00_data_q;
   assign m00_axis_tkeep  = m00_keep_q;
   assign m01_axis_tvalid = m01_valid_q;
   assign m01_axis_tdata  = m01_data_q;
   assign m01_axis_tkeep  = m01_keep_q;
   assign m01_axis_tlast  = m01_last_q;
   assign hdr_err         = hdr_err_q;

`ifdef AXIS_EXTRACT_HEADER_STATS_EN
   logic [31:0] pkt_cnt_q;
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (w_hs && s_axis_tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         if (hdr_err_d)            err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/axi_stream_extract_header.md
Name: axi_stream_extract_header

Overview:
- Inverse of the header-insert block: accepts an AXI-Stream packet whose first beat begins with a header of 0..DATA_BYTE_WD bytes.
- Splits the header onto its own stream and re-aligns the remaining payload to the MSB byte lane.
- Sits on the receive side, after the link and before payload consumers.
- Byte order is MSB-first: first byte in tdata[DATA_WD-1 -: 8]; tkeep on the last beat is high-aligned and contiguous (e.g. 4'b1100).

Parameters:
- DATA_WD, 32, data width in bits; must be a multiple of 8.
- DATA_BYTE_WD, DATA_WD/8, byte lanes (W below).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- hdr_len  in  $clog2(W+1)  header length in bytes (H); sampled on acceptance of each packet's first beat
- s_axis_tvalid  in  1  input stream valid
- s_axis_tdata  in  DATA_WD  input data
- s_axis_tkeep  in  W  input byte enables; all ones except on the tlast beat
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  input ready
- m00_axis_tvalid  out  1  header beat valid
- m00_axis_tdata  out  DATA_WD  header bytes, LSB-aligned
- m00_axis_tkeep  out  W  header keep, low-aligned ones
- m00_axis_tready  in  1  header ready
- m01_axis_tvalid  out  1  payload valid
- m01_axis_tdata  out  DATA_WD  payload, MSB-aligned
- m01_axis_tkeep  out  W  payload keep
- m01_axis_tlast  out  1  payload last
- m01_axis_tready  in  1  payload ready
- hdr_err  out  1  one-cycle pulse: packet ended before H header bytes arrived

Behaviour:
- Reset:
  - All m00/m01 outputs 0 and hdr_err 0.
  - FSM goes to HDR; carry register cleared.
  - s_axis_tready is 0 during reset, then follows the rules below.
  - Reset mid-packet discards all state; the next accepted beat is treated as a first beat.
- Output registers:
  - Each output has one registered slot; slot is free = !valid || ready.
  - Latency is 1 cycle from input handshake to output valid.
  - Full throughput when both consumers stay ready.
- Notation: k = popcount(s_axis_tkeep) on the tlast beat.
- State HDR (next beat is first of a packet):
  - tready = m00 free && m01 free.
  - On handshake, latch H.
  - H>0: m00 gets the top H bytes, placed in the low lanes; m00_tkeep = (1<<H)-1.
  - The W-H bytes after the header go to carry, MSB-aligned; carry count C = W-H.
  - H=0: no header beat; the first beat is treated as PAYLOAD input with C=0.
  - First beat with tlast, k<=H (H>0): m00 gets k bytes with tkeep=(1<<k)-1; hdr_err pulses if k<H; no payload beat; stay in HDR.
  - First beat with tlast, k>H: header beat plus one payload beat in the same cycle; payload = k-H bytes, tkeep high-aligned, tlast=1; stay in HDR.
  - Otherwise go to PAYLOAD.
- State PAYLOAD:
  - tready = m01 free.
  - Non-last beat: output = carry (C bytes) ++ first W-C bytes of the beat; tkeep all ones; new carry = remaining C bytes.
  - Last beat, total T = C+k:
    - T<=W: emit one beat, tkeep = top T ones, tlast=1; go to HDR.
    - T>W: emit a full beat, tlast=0; carry = T-W bytes; go to FLUSH.
  - C=0: beats pass through unchanged.
- State FLUSH:
  - tready = 0.
  - When m01 is free, emit carry with tkeep = top (T-W) ones and tlast=1; go to HDR.
- Header and payload outputs are independent. A stalled m00 only blocks the next packet's first beat.
- hdr_len changes mid-packet are ignored.
- H>W is clamped to W.

Optional Feature:
- Macro AXIS_EXTRACT_HEADER_STATS_EN.
- When defined, add outputs:
  - pkt_cnt[31:0]: increments on each accepted s_axis tlast beat.
  - err_cnt[15:0]: increments on each hdr_err pulse.
- Both counters are cleared by rst and wrap on overflow.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- W=4, H=2; beats 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3 (keep 1111, last) -> m00 0x0000A0A1 keep 0011; m01 0xA2A3B0B1 then 0xB2B3C0C1 (keep 1111), then flush 0xC2C3xxxx keep 1100 last.
- H=3; beats 0x11223344, 0x55667788 with keep 1000 last -> m00 0x00112233 keep 0111; m01 0x4455xxxx keep 1100 last; no flush cycle.
- H=0 on a 2-beat packet -> no m00 beat, m01 identical to input. H=4 -> m00 = beat 0 with keep 1111; m01 = beats 1.. unchanged.
- H=3; single beat 0x1122xxxx keep 1100 last -> m00 0x00001122 keep 0011; hdr_err pulses once; no m01 beat; err_cnt=1 when the feature is enabled.
- Random m01_tready, m00_tready held low 5 cycles over 20 back-to-back packets -> no byte lost or duplicated; s_axis_tready low on the next first beat while the m00 slot is occupied.
- rst asserted mid-packet, then a new packet with H=1 -> all outputs 0 the cycle after reset; the new packet is extracted correctly.
